// File: rtl/template_arb_pkg.sv
// Shared types for the template datapath arbiter.
// FSM encoding and counter sizing.
package template_arb_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/template_rr_picker.sv
// Combinational round-robin picker: first set request
// at or above the pointer, wrapping modulo N.
module template_rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic w_found;
  int   w_k;

  // scan N slots starting at the pointer, keep the first hit
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_k     = 0;
    for (int i = 0; i < N; i++) begin
      w_k = (int'(i_ptr) + i) % N;
      if (!w_found && i_req[w_k]) begin
        w_found    = 1'b1;
        o_gnt[w_k] = 1'b1;
        o_idx      = IW'(w_k);
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/template_arbiter.sv
// Round-robin owner of the template datapath: one
// transaction in flight, response routed back one-hot.
module template_arbiter
  import template_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int LATENCY = 1
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic [NUM_REQ-1:0]        o_rsp_valid,
  output logic [DATA_W-1:0]         o_rsp_data,
  input  logic [NUM_REQ-1:0]        i_rsp_ready,
  output logic [DATA_W-1:0]         o_dp_data,
  input  logic [DATA_W-1:0]         i_dp_data,
  output logic                      o_busy
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_t          r_state;
  logic [IW-1:0]       r_ptr;
  logic [IW-1:0]       r_gidx;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_dp_data;
  logic [DATA_W-1:0]   r_rsp_data;
  logic [NUM_REQ-1:0]  r_rsp_valid;

  logic [NUM_REQ-1:0]  w_gnt;
  logic [IW-1:0]       w_idx;
  logic                w_any;
  logic [DATA_W-1:0]   w_sel;
  logic                w_ack;
  logic [IW-1:0]       w_next_ptr;

  template_rr_picker #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_picker (
    .i_req (i_req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_sel = i_req_data[int'(w_idx)*DATA_W +: DATA_W];
  assign w_ack = i_rsp_ready[r_gidx];

  assign w_next_ptr = (r_gidx == IW'(NUM_REQ-1))
                    ? '0 : r_gidx + 1'b1;

  assign o_req_ready = (r_state == IDLE) ? w_gnt : '0;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_dp_data   = r_dp_data;
  assign o_busy      = (r_state != IDLE);

  // control FSM: accept, wait out the latency, hold response
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_gidx      <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gidx  <= w_idx;
            r_cnt   <= CNT_W'(LATENCY);
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_rsp_valid <= NUM_REQ'(1) << r_gidx;
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          if (w_ack) begin
            r_rsp_valid <= '0;
            r_ptr       <= w_next_ptr;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // payload registers: load on accept, capture on latency expiry
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_dp_data  <= '0;
      r_rsp_data <= '0;
    end else begin
      if (r_state == IDLE && w_any)
        r_dp_data <= w_sel;
      if (r_state == WAIT && r_cnt == '0)
        r_rsp_data <= i_dp_data;
    end
  end

endmodule
